// File: rtl/fft4_frame_loader.sv
// fft4_frame_loader: groups a serial complex sample stream into 4-sample
// frames and presents each frame in parallel (A..D) from a ping-pong
// double buffer, so the next frame loads while the current one is held.
module fft4_frame_loader #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Ar,
  output logic [W-1:0] Ai,
  output logic [W-1:0] Br,
  output logic [W-1:0] Bi,
  output logic [W-1:0] Cr,
  output logic [W-1:0] Ci,
  output logic [W-1:0] Dr,
  output logic [W-1:0] Di,
  output logic         frame_err
);

  logic [W-1:0] re_q [2][4];
  logic [W-1:0] re_d [2][4];
  logic [W-1:0] im_q [2][4];
  logic [W-1:0] im_d [2][4];
  logic [W-1:0] ore_q [4];
  logic [W-1:0] ore_d [4];
  logic [W-1:0] oim_q [4];
  logic [W-1:0] oim_d [4];
  logic [1:0]   full_q, full_d;
  logic         wb_q, wb_d;
  logic         rb_q, rb_d;
  logic [1:0]   idx_q, idx_d;
  logic         err_q, err_d;
  logic         accept;
  logic         consume;

  assign in_ready  = !full_q[wb_q];
  assign out_valid = full_q[rb_q];
  assign frame_err = err_q;
  assign accept    = in_valid && in_ready;
  assign consume   = full_q[rb_q] && out_ready;

  assign Ar = ore_q[0];
  assign Ai = oim_q[0];
  assign Br = ore_q[1];
  assign Bi = oim_q[1];
  assign Cr = ore_q[2];
  assign Ci = oim_q[2];
  assign Dr = ore_q[3];
  assign Di = oim_q[3];

  // Sample write, frame commit/discard, consume and framing-error detection
  always_comb begin
    re_d   = re_q;
    im_d   = im_q;
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    idx_d  = idx_q;
    err_d  = 1'b0;
    if (accept) begin
      re_d[wb_q][idx_q] = in_re;
      im_d[wb_q][idx_q] = in_im;
      if (idx_q == 2'd3) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        idx_d        = 2'd0;
        err_d        = !in_last;
      end else if (in_last) begin
        idx_d = 2'd0;
        err_d = 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
    // Commit targets a non-full bank and consume a full one, so they never collide
    if (consume) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  // Output registers track the bank that will be presented next cycle,
  // and otherwise hold, so A..D never follow a bank that is being refilled
  always_comb begin
    ore_d = ore_q;
    oim_d = oim_q;
    if (full_d[rb_d]) begin
      for (int unsigned i = 0; i < 4; i++) begin
        ore_d[i] = re_d[rb_d][i];
        oim_d[i] = im_d[rb_d][i];
      end
    end
  end

  // State register with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < 4; i++) begin
          re_q[b][i] <= '0;
          im_q[b][i] <= '0;
        end
      end
      for (int unsigned i = 0; i < 4; i++) begin
        ore_q[i] <= '0;
        oim_q[i] <= '0;
      end
      full_q <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      re_q   <= re_d;
      im_q   <= im_d;
      ore_q  <= ore_d;
      oim_q  <= oim_d;
      full_q <= full_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_fft4_frame_loader.sv
// Directed self-checking bench for fft4_frame_loader.
module tb_fft4_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_re;
  logic [31:0] in_im;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Ar, Ai, Br, Bi, Cr, Ci, Dr, Di;
  logic        frame_err;

  int tests = 0;
  int fails = 0;

  fft4_frame_loader #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .Ar(Ar), .Ai(Ai), .Br(Br), .Bi(Bi),
    .Cr(Cr), .Ci(Ci), .Dr(Dr), .Di(Di),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample (imag = -real) and wait, bounded, until it is accepted
  task automatic send(input logic [31:0] re, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = 32'd0 - re;
    in_last  = last;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_timeout: in_ready=%0b required 1 (re=%0d)", in_ready, re);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    send(32'd7, 1'b0);
    send(32'd8, 1'b0);
    send(32'd9, 1'b0);
    send(32'd10, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, frame_err} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags: rdy/vld/err=%b required 100", {in_ready, out_valid, frame_err});
    end
    tests++;
    if ({Ar, Ai, Br, Bi, Cr, Ci, Dr, Di} !== 256'd0) begin
      fails++;
      $display("FAIL reset_data: Ar=%0h Ai=%0h Dr=%0h Di=%0h required all 0", Ar, Ai, Dr, Di);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    out_ready = 1'b0;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_early_valid: out_valid=%0b required 0", out_valid);
    end
    send(32'd4, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (out_valid !== 1'b1 || frame_err !== 1'b0) begin
        fails++;
        $display("FAIL single_valid c%0d: out_valid=%0b err=%0b required 1 0", c, out_valid, frame_err);
      end
      tests++;
      if ({Ar, Br, Cr, Dr} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
        fails++;
        $display("FAIL single_re c%0d: %0d %0d %0d %0d required 1 2 3 4", c, Ar, Br, Cr, Dr);
      end
      tests++;
      if ({Ai, Bi, Ci, Di} !== {32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC}) begin
        fails++;
        $display("FAIL single_im c%0d: %h %h %h %h required ffffffff fffffffe fffffffd fffffffc", c, Ai, Bi, Ci, Di);
      end
      tick();
    end
    pulse_consume();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_consume: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_pressure();
    int acc;
    logic took;
    acc       = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1;
      in_re    = 32'd100 + 32'(acc);
      in_im    = 32'd0 - in_re;
      in_last  = (acc % 4) == 3;
      took     = in_ready;
      tick();
      if (took) acc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests++;
    if (acc != 8 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept_count: accepted=%0d in_ready=%0b required 8 0", acc, in_ready);
    end
    tests++;
    if (out_valid !== 1'b1 || {Ar, Br, Cr, Dr} !== {32'd100, 32'd101, 32'd102, 32'd103}) begin
      fails++;
      $display("FAIL bp_frame1: vld=%0b %0d %0d %0d %0d required 1 100 101 102 103", out_valid, Ar, Br, Cr, Dr);
    end
    pulse_consume();
    tests++;
    if (out_valid !== 1'b1 || {Ar, Br, Cr, Dr} !== {32'd104, 32'd105, 32'd106, 32'd107}) begin
      fails++;
      $display("FAIL bp_frame2: vld=%0b %0d %0d %0d %0d required 1 104 105 106 107", out_valid, Ar, Br, Cr, Dr);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready_after_consume: in_ready=%0b required 1", in_ready);
    end
    send(32'd200, 1'b0);
    send(32'd201, 1'b0);
    send(32'd202, 1'b0);
    send(32'd203, 1'b1);
    tests++;
    if ({Ar, Dr} !== {32'd104, 32'd107}) begin
      fails++;
      $display("FAIL bp_frame2_hold: Ar=%0d Dr=%0d required 104 107", Ar, Dr);
    end
    pulse_consume();
    tests++;
    if (out_valid !== 1'b1 || {Ar, Br, Cr, Dr} !== {32'd200, 32'd201, 32'd202, 32'd203}) begin
      fails++;
      $display("FAIL bp_frame3: vld=%0b %0d %0d %0d %0d required 1 200 201 202 203", out_valid, Ar, Br, Cr, Dr);
    end
    pulse_consume();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] b;
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      in_valid = 1'b1;
      in_re    = 32'd300 + 32'(n);
      in_im    = 32'd0 - in_re;
      in_last  = (n % 4) == 3;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_ready n%0d: in_ready=%0b required 1", n, in_ready);
      end
      tick();
      if ((n % 4) == 3) begin
        b = 32'd300 + 32'(n - 3);
        tests++;
        if (out_valid !== 1'b1 || {Ar, Br, Cr, Dr} !== {b, b + 32'd1, b + 32'd2, b + 32'd3}) begin
          fails++;
          $display("FAIL stream_frame n%0d: vld=%0b %0d %0d %0d %0d required 1 %0d..%0d",
                   n, out_valid, Ar, Br, Cr, Dr, b, b + 32'd3);
        end
      end else if ((n % 4) == 0 && n > 0) begin
        tests++;
        if (out_valid !== 1'b0) begin
          fails++;
          $display("FAIL stream_gap n%0d: out_valid=%0b required 0", n, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL stream_end: out_valid=%0b err=%0b required 0 0", out_valid, frame_err);
    end
  endtask

  task automatic test_short_frame();
    out_ready = 1'b0;
    send(32'd5, 1'b0);
    send(32'd6, 1'b1);
    tests++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL short_err: err=%0b vld=%0b required 1 0", frame_err, out_valid);
    end
    tick();
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL short_err_pulse: err=%0b required 0", frame_err);
    end
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b0);
    send(32'd40, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || frame_err !== 1'b0 ||
        {Ar, Br, Cr, Dr} !== {32'd10, 32'd20, 32'd30, 32'd40}) begin
      fails++;
      $display("FAIL short_next_frame: vld=%0b err=%0b %0d %0d %0d %0d required 1 0 10 20 30 40",
               out_valid, frame_err, Ar, Br, Cr, Dr);
    end
    pulse_consume();
  endtask

  task automatic test_missing_last();
    out_ready = 1'b0;
    send(32'd50, 1'b0);
    send(32'd51, 1'b0);
    send(32'd52, 1'b0);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL miss_early_err: err=%0b required 0", frame_err);
    end
    send(32'd53, 1'b0);
    tests++;
    if (frame_err !== 1'b1 || out_valid !== 1'b1 ||
        {Ar, Br, Cr, Dr} !== {32'd50, 32'd51, 32'd52, 32'd53}) begin
      fails++;
      $display("FAIL miss_commit: err=%0b vld=%0b %0d %0d %0d %0d required 1 1 50 51 52 53",
               frame_err, out_valid, Ar, Br, Cr, Dr);
    end
    tick();
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL miss_err_pulse: err=%0b required 0", frame_err);
    end
    pulse_consume();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b0;
    send(32'd60, 1'b0);
    send(32'd61, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_state: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
    send(32'd70, 1'b0);
    send(32'd71, 1'b0);
    send(32'd72, 1'b0);
    send(32'd73, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || frame_err !== 1'b0 ||
        {Ar, Ai, Br, Cr, Dr, Di} !== {32'd70, 32'hFFFFFFBA, 32'd71, 32'd72, 32'd73, 32'hFFFFFFB7}) begin
      fails++;
      $display("FAIL rstmid_frame: vld=%0b err=%0b Ar=%0d Ai=%h Br=%0d Cr=%0d Dr=%0d Di=%h required 1 0 70 ffffffba 71 72 73 ffffffb7",
               out_valid, frame_err, Ar, Ai, Br, Cr, Dr, Di);
    end
    pulse_consume();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_single_frame();
    test_back_pressure();
    test_streaming();
    test_short_frame();
    test_missing_last();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
